// File: rtl/xgmii_rx_deframer.sv
// XGMII receive deframer: strips /S/, preamble and SFD from lane-0-aligned words and streams
// payload (FCS included) through a one-word hold register with framing, length and error flags.
module xgmii_rx_deframer #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        xgmii_clk,
    input  logic        sys_rst,
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [7:0]  out_be,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [15:0] out_len,
    output logic [31:0] stat_good,
    output logic [31:0] stat_bad
);
    // state | meaning
    // IDLE  | waiting for a /S/ word carrying a valid SFD
    // DATA  | payload streaming through the hold register
    // FLUSH | final partial word sits in the hold register; emit it with eof
    // DROP  | discarding until a terminate or an all-control word
    typedef enum logic [1:0] {IDLE, DATA, FLUSH, DROP} state_t;

    localparam logic [16:0] MAX_L    = 17'(MAX_LEN);
    localparam logic [15:0] MAX_L16  = 16'(MAX_LEN);
    localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
    localparam logic [7:0]  CH_START = 8'hFB;
    localparam logic [7:0]  CH_TERM  = 8'hFD;
    localparam logic [7:0]  CH_SFD   = 8'hD5;

    function automatic logic [7:0] low_mask(input logic [3:0] n);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

    function automatic logic [63:0] lane_expand(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [63:0] h_data, h_data_nxt;
    logic [7:0]  h_be, h_be_nxt;
    logic        h_valid, h_valid_nxt, h_sof, h_sof_nxt;
    logic        sof_pending, sof_pending_nxt;
    logic        flush_err, flush_err_nxt, flush_drop, flush_drop_nxt;
    logic [15:0] len, len_nxt;

    logic        o_valid_n, o_sof_n, o_eof_n, o_err_n;
    logic [63:0] o_data_n;
    logic [7:0]  o_be_n;
    logic [15:0] o_len_n;
    logic        good_add;
    logic [1:0]  bad_add;

    logic        is_start, sfd_ok, term_any, t_is_term, no_ctl, all_ctl, load_word, over;
    logic [2:0]  t_lane;
    logic [3:0]  bytes_in, keep_room, keep_bytes;
    logic [16:0] len_sum;

    always_comb begin
        t_lane   = 3'd0;
        term_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (rxc[i]) t_lane = 3'(i);
        end
        for (int i = 0; i < 8; i++) begin
            if (rxc[i] && rxd[8*i +: 8] == CH_TERM) term_any = 1'b1;
        end
    end

    assign no_ctl     = (rxc == 8'h00);
    assign all_ctl    = (rxc == 8'hFF);
    assign is_start   = rxc[0] && (rxc[7:1] == 7'd0) && (rxd[7:0] == CH_START);
    assign sfd_ok     = (rxd[63:56] == CH_SFD);
    assign t_is_term  = (rxd[{t_lane, 3'b000} +: 8] == CH_TERM);
    assign load_word  = no_ctl || (t_lane != 3'd0 && t_is_term);
    assign bytes_in   = no_ctl ? 4'd8 : {1'b0, t_lane};
    assign len_sum    = {1'b0, len} + {13'd0, bytes_in};
    assign over       = (len_sum > MAX_L);
    assign keep_room  = 4'(MAX_L16 - len);
    assign keep_bytes = over ? keep_room : bytes_in;

    always_ff @(posedge xgmii_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            h_data      <= '0;
            h_be        <= '0;
            h_valid     <= 1'b0;
            h_sof       <= 1'b0;
            sof_pending <= 1'b0;
            flush_err   <= 1'b0;
            flush_drop  <= 1'b0;
            len         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_be      <= '0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_err     <= 1'b0;
            out_len     <= '0;
            stat_good   <= '0;
            stat_bad    <= '0;
        end else begin
            state       <= state_nxt;
            h_data      <= h_data_nxt;
            h_be        <= h_be_nxt;
            h_valid     <= h_valid_nxt;
            h_sof       <= h_sof_nxt;
            sof_pending <= sof_pending_nxt;
            flush_err   <= flush_err_nxt;
            flush_drop  <= flush_drop_nxt;
            len         <= len_nxt;
            out_valid   <= o_valid_n;
            out_data    <= o_data_n;
            out_be      <= o_be_n;
            out_sof     <= o_sof_n;
            out_eof     <= o_eof_n;
            out_err     <= o_err_n;
            out_len     <= o_len_n;
            stat_good   <= stat_good + {31'd0, good_add};
            stat_bad    <= stat_bad + {30'd0, bad_add};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_start) state_nxt = sfd_ok ? DATA : DROP;
            DATA: begin
                if (load_word) begin
                    if (over && keep_bytes == 4'd0) state_nxt = term_any ? IDLE : DROP;
                    else if (no_ctl && !over)       state_nxt = DATA;
                    else                            state_nxt = FLUSH;
                end else begin
                    state_nxt = term_any ? IDLE : DROP;
                end
            end
            FLUSH: begin
                if (flush_drop)    state_nxt = (term_any || all_ctl) ? IDLE : DROP;
                else if (is_start) state_nxt = sfd_ok ? DATA : DROP;
                else               state_nxt = IDLE;
            end
            DROP: if (term_any || all_ctl) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        logic emit_h, emit_eof, eof_err, eof_bad, sfd_bad, take_start;
        emit_h          = 1'b0;
        emit_eof        = 1'b0;
        eof_err         = 1'b0;
        take_start      = 1'b0;
        h_data_nxt      = h_data;
        h_be_nxt        = h_be;
        h_valid_nxt     = h_valid;
        h_sof_nxt       = h_sof;
        sof_pending_nxt = sof_pending;
        flush_err_nxt   = flush_err;
        flush_drop_nxt  = flush_drop;
        len_nxt         = len;
        case (state)
            IDLE: take_start = 1'b1;
            DATA: begin
                emit_h = 1'b1;
                if (load_word && !(over && keep_bytes == 4'd0)) begin
                    h_data_nxt      = rxd & lane_expand(low_mask(keep_bytes));
                    h_be_nxt        = low_mask(keep_bytes);
                    h_valid_nxt     = 1'b1;
                    h_sof_nxt       = sof_pending;
                    sof_pending_nxt = 1'b0;
                    len_nxt         = over ? MAX_L16 : len_sum[15:0];
                    flush_err_nxt   = over;
                    flush_drop_nxt  = over && no_ctl;
                end else begin
                    // terminate in lane 0, a stray control character, or overflow with no room left
                    emit_eof    = 1'b1;
                    eof_err     = load_word || !(t_lane == 3'd0 && t_is_term);
                    h_valid_nxt = 1'b0;
                end
            end
            FLUSH: begin
                emit_h      = 1'b1;
                emit_eof    = 1'b1;
                eof_err     = flush_err;
                h_valid_nxt = 1'b0;
                take_start  = !flush_drop;
            end
            default: ;
        endcase

        sfd_bad = take_start && is_start && !sfd_ok;
        if (take_start && is_start && sfd_ok) begin
            len_nxt         = '0;
            sof_pending_nxt = 1'b1;
            h_valid_nxt     = 1'b0;
            flush_err_nxt   = 1'b0;
            flush_drop_nxt  = 1'b0;
        end

        eof_bad   = eof_err || (len < MIN_L);
        o_valid_n = 1'b0;
        o_data_n  = '0;
        o_be_n    = '0;
        o_sof_n   = 1'b0;
        o_eof_n   = 1'b0;
        o_err_n   = 1'b0;
        o_len_n   = '0;
        if (emit_h && h_valid) begin
            o_valid_n = 1'b1;
            o_data_n  = h_data;
            o_be_n    = h_be;
            o_sof_n   = h_sof;
            o_eof_n   = emit_eof;
            o_err_n   = emit_eof && eof_bad;
            o_len_n   = emit_eof ? len : 16'd0;
        end
        // a frame ending before any payload was held still counts as bad
        good_add = emit_eof && h_valid && !eof_bad;
        bad_add  = 2'(emit_eof && !(h_valid && !eof_bad)) + 2'(sfd_bad);
    end
endmodule

// File: doc/xgmii_rx_deframer.md
Name: xgmii_rx_deframer

Overview:
- Receive-side framing stage between the lane-0-aligned XGMII sync output (xgmii_rxd2/xgmii_rxc2) and user receive parsers in app.
- Detects /S/ + preamble/SFD, strips them, and emits 64-bit payload words with byte enables, SOF/EOF, byte length and error flag. FCS bytes are passed through unstripped.
- Keeps good/bad frame statistics. No backpressure: output runs at line rate.

Parameters:
MAX_LEN, 1518, maximum frame length in bytes incl. FCS; longer frames are truncated and flagged.
MIN_LEN, 64, minimum frame length in bytes incl. FCS; shorter frames are flagged as runt.

Ports:
xgmii_clk  in  1  single clock, all logic on posedge
sys_rst  in  1  synchronous, active-high reset
rxd  in  64  XGMII data, lane 0 = [7:0]; /S/ only ever in lane 0
rxc  in  8  XGMII control, bit i qualifies lane i
out_valid  out  1  output word valid
out_data  out  64  payload bytes, first byte in [7:0]
out_be  out  8  byte enables, contiguous from bit 0
out_sof  out  1  first word of frame
out_eof  out  1  last word of frame
out_err  out  1  frame bad; valid only with out_eof
out_len  out  16  frame byte count incl. FCS; valid only with out_eof
stat_good  out  32  count of frames ended without error, wraps
stat_bad  out  32  count of frames ended with error, wraps

Behaviour:
- Reset: all outputs 0; state IDLE; hold register empty. Applies mid-frame: no EOF is emitted for the aborted frame and no counter increments.
- States: IDLE, DATA, FLUSH, DROP.
- IDLE:
  - Start word is rxc[0]=1, rxd[7:0]=FB, rxc[7:1]=0.
  - If rxd[63:56]=D5 (SFD): go to DATA, clear len, set sof_pending.
  - If SFD is bad: go to DROP and count bad. No output words are produced for that frame.
- DATA: a one-word hold register H sits between input and output. Per input word, T = lowest lane with rxc=1.
  - No control bits: out <= H with eof=0 if H is valid; H <= word, be=FF; len += 8.
  - T=0 and rxd[7:0]=FD: out <= H with eof=1, using final len; go to IDLE.
  - T>0 and lane T = FD: out <= H with eof=0; H <= lanes 0..T-1 with be=(1<<T)-1; len += T; go to FLUSH.
  - Any other control character (FE, or no FD found): out <= H with eof=1, err=1; go to DROP if the terminate has not been seen, else IDLE.
- FLUSH: out <= H with eof=1; go to IDLE. A start word seen in this cycle is handled exactly as in IDLE.
- DROP: outputs idle; return to IDLE on a word containing FD in any lane, or on rxc=FF.
- Latency: a payload byte entering at cycle t appears on out at t+2.
- out_sof is set on the first word emitted after the start word. A 1-word frame has sof=eof=1.
- Length rules:
  - If len would exceed MAX_LEN: emit H and the current word truncated to MAX_LEN bytes, with eof=1, err=1, out_len=MAX_LEN; go to DROP.
  - At EOF, len < MIN_LEN forces err=1.
- Statistics: on every emitted eof, increment stat_good if err=0, else stat_bad.
  - Bad SFD increments stat_bad with no output.
  - Both counters wrap at 2^32.
- Outputs are registered. out_valid=0 leaves out_data don't-care; out_be, sof, eof and err are all 0 then.

Test Plan:
- 64-byte frame (start word, 8 full words, then FD in lane 0 with rest 07) -> 8 output words with be=FF; sof on word 1; eof on word 8; out_len=64; err=0; stat_good=1.
- 68-byte UDP frame as produced by the app transmitter (8 full words, word with 4 data bytes and FD in lane 4) -> 9 words, last be=0F, out_len=68, err=0, FCS bytes matching the input.
- 60-byte runt (7 full words, 4 bytes, FD in lane 4) -> eof with be=0F, out_len=60, err=1, stat_bad=1.
- FE in lane 3 of word 5, with FD two words later -> eof on word 4 with err=1; no further output until the FD word is seen; then IDLE; the next valid frame is accepted.
- Oversize 2000-byte frame with MAX_LEN=1518 -> eof with out_len=1518, err=1; DROP until FD; stat_bad increments once.
- Start word with rxd[63:56]=55 (bad SFD) -> no output; stat_bad+1. Separately, sys_rst asserted mid-frame -> all outputs 0 the next cycle and counters 0; the following frame is decoded normally.
